fp32_result_sink: RTL and testbench

FP32_RESULT_SINK -- requirements
Module: fp32_result_sink

---
 rtl/fp32_result_sink.sv | 145 ++++++++++++++
 tb/tb_fp32_result_sink.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_result_sink.sv
// Collects FP32 multiplier results: delays operand tags to line up with y,
// then queues {x1, x2, y, over} in a FIFO for a ready/valid consumer.
module fp32_result_sink #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       val,
    input  logic                       over,
    input  logic [31:0]                x1,
    input  logic [31:0]                x2,
    input  logic [31:0]                y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_x1,
    output logic [31:0]                out_x2,
    output logic [31:0]                out_y,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0] tag_val_r;
    logic [LATENCY-1:0] tag_over_r;
    logic [31:0]        tag_x1_r [LATENCY];
    logic [31:0]        tag_x2_r [LATENCY];

    logic [31:0]        mem_x1_r [DEPTH];
    logic [31:0]        mem_x2_r [DEPTH];
    logic [31:0]        mem_y_r  [DEPTH];
    logic [DEPTH-1:0]   mem_last_r;

    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               overflow_r;
    logic               done_r;

    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               wr_s;

    assign push_s = en & tag_val_r[LATENCY-1];
    assign pop_s  = (count_r != {CW{1'b0}}) & out_ready;
    assign full_s = (count_r == CW'(DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    assign wr_s   = push_s & (~full_s | pop_s);

    // Tag control bits: shift on enabled cycles, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_val_r  <= {LATENCY{1'b0}};
            tag_over_r <= {LATENCY{1'b0}};
        end else if (en) begin
            tag_val_r[0]  <= val;
            tag_over_r[0] <= over;
            for (int i = 1; i < LATENCY; i++) begin
                tag_val_r[i]  <= tag_val_r[i-1];
                tag_over_r[i] <= tag_over_r[i-1];
            end
        end else begin
            tag_val_r  <= tag_val_r;
            tag_over_r <= tag_over_r;
        end
    end

    // Tag operand payload: qualified by tag_val_r, so it needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            tag_x1_r[0] <= x1;
            tag_x2_r[0] <= x2;
            for (int i = 1; i < LATENCY; i++) begin
                tag_x1_r[i] <= tag_x1_r[i-1];
                tag_x2_r[i] <= tag_x2_r[i-1];
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_x1_r[wr_ptr_r]   <= tag_x1_r[LATENCY-1];
            mem_x2_r[wr_ptr_r]   <= tag_x2_r[LATENCY-1];
            mem_y_r[wr_ptr_r]    <= y;
            mem_last_r[wr_ptr_r] <= tag_over_r[LATENCY-1];
        end
    end

    // FIFO pointers, occupancy and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s & full_s & ~pop_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s & mem_last_r[rd_ptr_r]) begin
                done_r <= 1'b1;
            end
        end
    end

    // Head presentation, forced to zero while the FIFO is empty.
    always_comb begin
        out_valid = 1'b0;
        out_x1    = 32'h0000_0000;
        out_x2    = 32'h0000_0000;
        out_y     = 32'h0000_0000;
        out_last  = 1'b0;
        if (count_r != {CW{1'b0}}) begin
            out_valid = 1'b1;
            out_x1    = mem_x1_r[rd_ptr_r];
            out_x2    = mem_x2_r[rd_ptr_r];
            out_y     = mem_y_r[rd_ptr_r];
            out_last  = mem_last_r[rd_ptr_r];
        end else begin
            out_valid = 1'b0;
        end
    end

    assign count    = count_r;
    assign overflow = overflow_r;
    assign done     = done_r;
endmodule

// File: tb/tb_fp32_result_sink.sv
// Directed bench for fp32_result_sink; the external multiplier is modelled
// as a 4-stage en-gated delay line carrying hand-computed products.
module tb_fp32_result_sink;
    logic        clk = 1'b0;
    logic        rst, en, val, over, out_ready;
    logic [31:0] x1, x2, y, prod;
    logic        out_valid, out_last, overflow, done;
    logic [31:0] out_x1, out_x2, out_y;
    logic [3:0]  count;
    logic [31:0] ypipe [4];
    logic [31:0] op_a [9];
    logic [31:0] op_b [9];
    logic [31:0] op_p [9];
    int          total = 0;
    int          bad   = 0;

    fp32_result_sink #(.LATENCY(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .val(val), .over(over),
        .x1(x1), .x2(x2), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x1(out_x1), .out_x2(out_x2), .out_y(out_y), .out_last(out_last),
        .count(count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en) begin
            ypipe[0] <= prod;
            ypipe[1] <= ypipe[0];
            ypipe[2] <= ypipe[1];
            ypipe[3] <= ypipe[2];
        end
    end
    assign y = ypipe[3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic o, input int k);
        val  = v;
        over = o;
        x1   = op_a[k];
        x2   = op_b[k];
        prod = op_p[k];
    endtask

    task automatic idle;
        val  = 1'b0;
        over = 1'b0;
        x1   = 32'h0;
        x2   = 32'h0;
        prod = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int k, input logic last);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, ".x1"}, out_x1, op_a[k]);
        chk({tag, ".x2"}, out_x2, op_b[k]);
        chk({tag, ".y"}, out_y, op_p[k]);
        chk({tag, ".last"}, {31'h0, out_last}, {31'h0, last});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, ".x1"}, out_x1, 32'h0);
        chk({tag, ".x2"}, out_x2, 32'h0);
        chk({tag, ".y"}, out_y, 32'h0);
        chk({tag, ".last"}, {31'h0, out_last}, 32'h0);
        chk({tag, ".count"}, {28'h0, count}, 32'h0);
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 0);
        tick();
        rst = 1'b1;
        idle();
    endtask

    initial begin
        // 1*2, 3*4, 2*2, 2*3, 1*1, 4*4, 2*4, 3*3, 1*3
        op_a = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 32'h3F800000,
                 32'h40800000, 32'h40000000, 32'h40400000, 32'h3F800000};
        op_b = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h40400000, 32'h3F800000,
                 32'h40800000, 32'h40800000, 32'h40400000, 32'h40400000};
        op_p = '{32'h40000000, 32'h41400000, 32'h40800000, 32'h40C00000, 32'h3F800000,
                 32'h41800000, 32'h41000000, 32'h41100000, 32'h40400000};
        for (int i = 0; i < 4; i++) ypipe[i] = 32'h0;
        rst = 1'b0; en = 1'b0; out_ready = 1'b0;
        idle();
        tick();
        do_reset();
        chk_empty("reset");
        chk("reset.overflow", {31'h0, overflow}, 32'h0);
        chk("reset.done", {31'h0, done}, 32'h0);

        // Basic latency and pairing
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 0); tick();
        drive(1'b1, 1'b0, 1); tick();
        idle(); tick(); tick();
        chk("lat.c4_valid", {31'h0, out_valid}, 32'h0);
        tick();
        chk_head("lat.p0", 0, 1'b0);
        chk("lat.p0_count", {28'h0, count}, 32'h1);
        tick();
        chk_head("lat.p1", 1, 1'b0);
        tick();
        chk_empty("lat.drained");

        // Enable stall for 3 cycles with val high while stalled
        drive(1'b1, 1'b0, 2); tick();
        drive(1'b1, 1'b0, 3); tick();
        en = 1'b0;
        drive(1'b1, 1'b0, 8); tick(); tick(); tick();
        en = 1'b1;
        idle(); tick(); tick();
        chk("stall.c7_valid", {31'h0, out_valid}, 32'h0);
        tick();
        chk_head("stall.p2", 2, 1'b0);
        tick();
        chk_head("stall.p3", 3, 1'b0);
        tick();
        chk_empty("stall.drained");

        // Overflow: 9 pairs into an 8-deep FIFO with no consumer
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, k); tick();
        end
        idle(); tick(); tick(); tick();
        chk("ovf.c12_count", {28'h0, count}, 32'h8);
        chk("ovf.c12_overflow", {31'h0, overflow}, 32'h0);
        tick();
        chk("ovf.c13_count", {28'h0, count}, 32'h8);
        chk("ovf.c13_overflow", {31'h0, overflow}, 32'h1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk_head($sformatf("ovf.pop%0d", k), k, 1'b0);
            tick();
        end
        chk_empty("ovf.drained");
        chk("ovf.sticky", {31'h0, overflow}, 32'h1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, k); tick();
        end
        idle(); tick(); tick(); tick();
        chk("full.c12_count", {28'h0, count}, 32'h8);
        out_ready = 1'b1;
        tick();
        chk("full.c13_count", {28'h0, count}, 32'h8);
        chk("full.c13_overflow", {31'h0, overflow}, 32'h0);
        for (int k = 1; k < 9; k++) begin
            chk_head($sformatf("full.pop%0d", k), k, 1'b0);
            tick();
        end
        chk_empty("full.drained");

        // Over tag, done flag, operation after done
        do_reset();
        out_ready = 1'b1;
        chk("last.done_init", {31'h0, done}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, (k == 4), k); tick();
        end
        idle();
        for (int k = 0; k < 5; k++) begin
            chk_head($sformatf("last.pop%0d", k), k, (k == 4));
            chk($sformatf("last.done%0d", k), {31'h0, done}, 32'h0);
            tick();
        end
        chk("last.done_set", {31'h0, done}, 32'h1);
        chk_empty("last.drained");
        drive(1'b1, 1'b0, 5); tick();
        idle(); tick(); tick(); tick(); tick();
        chk_head("after_done.p5", 5, 1'b0);
        chk("after_done.done", {31'h0, done}, 32'h1);
        tick();
        chk_empty("after_done.drained");

        // Reset mid-run with 3 tags in flight and 2 entries queued
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, k); tick();
        end
        idle(); tick();
        chk("midrst.queued", {28'h0, count}, 32'h2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_empty("midrst.after");
        chk("midrst.overflow", {31'h0, overflow}, 32'h0);
        chk("midrst.done", {31'h0, done}, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("midrst.quiet%0d", k), {31'h0, out_valid}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
